// File: rtl/jpeg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jpeg_pkg                                                         |
// | Shared constants and types for the dequant / de-zigzag block.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package jpeg_pkg;

  localparam int BLOCK_LAST = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2
  } rd_state_t;

  // Zigzag scan position -> natural (row-major) position in the 8x8 block.
  localparam logic [5:0] C_ZZ2NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] dezigzag(input logic [5:0] zz);
    return C_ZZ2NAT[zz];
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_dequant_qtable_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jpeg_dequant_qtable_ram                                          |
// | Quantisation table store: 1 write port, 1 synchronous read port. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jpeg_dequant_qtable_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rd_data;

  // Read samples the array before this edge's write lands: old-value semantics.
  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/jpeg_dequant_dezigzag.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jpeg_dequant_dezigzag                                            |
// | Dequantises zigzag coefficients into a ping-pong natural buffer. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jpeg_dequant_dezigzag
  import jpeg_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int NUM_QT  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      img_start_i,
  input  logic                      dqt_wr_i,
  input  logic [$clog2(NUM_QT)-1:0] dqt_table_i,
  input  logic [5:0]                dqt_idx_i,
  input  logic [7:0]                dqt_data_i,
  input  logic                      inport_valid_i,
  input  logic [COEFF_W-1:0]        inport_data_i,
  input  logic [5:0]                inport_idx_i,
  input  logic [$clog2(NUM_QT)-1:0] inport_table_i,
  input  logic                      inport_last_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [31:0]               outport_data_o,
  output logic [5:0]                outport_idx_o,
  input  logic                      yumi_i
);

  logic              w_accept;
  logic [7:0]        w_q;
  logic [23:0]       w_prod;
  logic [5:0]        w_rd_addr;
  logic [23:0]       w_buf_word;
  logic [31:0]       w_rd_word;

  logic [1:0]        r_block_ready;
  logic              r_block_wr;
  logic              r_block_rd;
  logic [63:0]       r_valid [2];
  logic [23:0]       r_buf [2][64];

  logic              r_p_valid;
  logic              r_p_last;
  logic              r_p_bank;
  logic [COEFF_W-1:0] r_p_data;
  logic [5:0]        r_p_nat;

  rd_state_t         r_state;
  logic [5:0]        r_rd_idx;
  logic              r_v;
  logic [31:0]       r_out_data;

  assign ready_o  = ~r_block_ready[r_block_wr];
  assign w_accept = inport_valid_i & ready_o;

  jpeg_dequant_qtable_ram #(
    .ADDR_W(6 + $clog2(NUM_QT))
  ) u_qtable (
    .clk_i     (clk_i),
    .i_wr_en   (dqt_wr_i),
    .i_wr_addr ({dqt_table_i, dqt_idx_i}),
    .i_wr_data (dqt_data_i),
    .i_rd_en   (w_accept),
    .i_rd_addr ({inport_table_i, inport_idx_i}),
    .o_rd_data (w_q)
  );

  // 16b signed x 8b unsigned always fits in 24 signed bits.
  assign w_prod = $signed({{(24-COEFF_W){r_p_data[COEFF_W-1]}}, r_p_data}) *
                  $signed({16'd0, w_q});

  assign w_rd_addr  = (r_state == SETUP) ? 6'd0 : r_rd_idx + 6'd1;
  assign w_buf_word = r_buf[r_block_rd][w_rd_addr];
  assign w_rd_word  = r_valid[r_block_rd][w_rd_addr] ?
                      {{8{w_buf_word[23]}}, w_buf_word} : 32'd0;

  always_ff @(posedge clk_i) begin
    if (r_p_valid) r_buf[r_p_bank][r_p_nat] <= w_prod;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      r_block_ready <= '0;
      r_block_wr    <= 1'b0;
      r_block_rd    <= 1'b0;
      r_valid[0]    <= '0;
      r_valid[1]    <= '0;
      r_p_valid     <= 1'b0;
      r_p_last      <= 1'b0;
      r_p_bank      <= 1'b0;
      r_p_data      <= '0;
      r_p_nat       <= '0;
      r_state       <= IDLE;
      r_rd_idx      <= '0;
      r_v           <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_p_data <= inport_data_i;
        r_p_nat  <= dezigzag(inport_idx_i);
        r_p_bank <= r_block_wr;
        r_p_last <= inport_last_i;
        if (inport_last_i) r_block_wr <= ~r_block_wr;
      end

      case (r_state)
        IDLE: begin
          if (r_block_ready[r_block_rd]) r_state <= SETUP;
        end
        SETUP: begin
          r_state    <= ACTIVE;
          r_v        <= 1'b1;
          r_rd_idx   <= '0;
          r_out_data <= w_rd_word;
        end
        ACTIVE: begin
          if (yumi_i) begin
            if (r_rd_idx == 6'(BLOCK_LAST)) begin
              r_block_ready[r_block_rd] <= 1'b0;
              r_valid[r_block_rd]       <= '0;
              r_block_rd                <= ~r_block_rd;
              r_state                   <= IDLE;
              r_v                       <= 1'b0;
              r_rd_idx                  <= '0;
              r_out_data                <= '0;
            end else begin
              r_rd_idx   <= r_rd_idx + 6'd1;
              r_out_data <= w_rd_word;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // The released bank is never the one being written, so these never collide.
      if (r_p_valid) begin
        r_valid[r_p_bank][r_p_nat] <= 1'b1;
        if (r_p_last) r_block_ready[r_p_bank] <= 1'b1;
      end
    end
  end

  assign v_o            = r_v;
  assign outport_idx_o  = r_rd_idx;
  assign outport_data_o = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_dequant_dezigzag.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jpeg_dequant_dezigzag                                         |
// | Directed stimulus with a block-level reference model.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_jpeg_dequant_dezigzag;

  logic        clk = 1'b0;
  logic        rst_i, img_start_i, dqt_wr_i;
  logic [1:0]  dqt_table_i;
  logic [5:0]  dqt_idx_i;
  logic [7:0]  dqt_data_i;
  logic        inport_valid_i;
  logic [15:0] inport_data_i;
  logic [5:0]  inport_idx_i;
  logic [1:0]  inport_table_i;
  logic        inport_last_i;
  logic        ready_o, v_o;
  logic [31:0] outport_data_o;
  logic [5:0]  outport_idx_o;
  logic        yumi_i = 1'b0;

  always #5 clk = ~clk;

  jpeg_dequant_dezigzag dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .img_start_i    (img_start_i),
    .dqt_wr_i       (dqt_wr_i),
    .dqt_table_i    (dqt_table_i),
    .dqt_idx_i      (dqt_idx_i),
    .dqt_data_i     (dqt_data_i),
    .inport_valid_i (inport_valid_i),
    .inport_data_i  (inport_data_i),
    .inport_idx_i   (inport_idx_i),
    .inport_table_i (inport_table_i),
    .inport_last_i  (inport_last_i),
    .ready_o        (ready_o),
    .v_o            (v_o),
    .outport_data_o (outport_data_o),
    .outport_idx_o  (outport_idx_o),
    .yumi_i         (yumi_i)
  );

  typedef int blk_t [64];

  int          errors = 0;
  int          checks = 0;
  int          zz2nat [64];
  int          qm [4][64];
  blk_t        cur;
  blk_t        exp_q [$];
  logic [31:0] got [16][64];
  int          rx_blk = 0;
  int          rx_idx = 0;
  int          ymode  = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Zigzag derived by walking the anti-diagonals of the 8x8 grid.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zz2nat[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zz2nat[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (ymode)
      0:       yumi_i = 1'b0;
      1:       yumi_i = 1'b1;
      default: yumi_i = ~yumi_i;
    endcase
  end

  always @(negedge clk) begin
    if (img_start_i) begin
      if (v_o) rx_blk++;
      exp_q.delete();
      rx_idx = 0;
    end else if (!rst_i && v_o) begin
      if (exp_q.size() == 0) begin
        chk("v_o_without_block", {31'd0, v_o}, 32'd0);
      end else begin
        chk("out_idx", {26'd0, outport_idx_o}, rx_idx);
        chk("out_data", outport_data_o, exp_q[0][rx_idx]);
        if (yumi_i) begin
          if (rx_blk < 16) got[rx_blk][rx_idx] = outport_data_o;
          if (rx_idx == 63) begin
            void'(exp_q.pop_front());
            rx_idx = 0;
            rx_blk++;
          end else begin
            rx_idx++;
          end
        end
      end
    end
  end

  task automatic send(input int data, input int zz, input int tbl, input bit last);
    bit acc = 1'b0;
    int guard = 0;
    inport_valid_i = 1'b1;
    inport_data_i  = 16'(data);
    inport_idx_i   = 6'(zz);
    inport_table_i = 2'(tbl);
    inport_last_i  = last;
    while (!acc && guard < 3000) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #2;
      guard++;
    end
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: zz %0d not accepted, ready_o %0b", zz, ready_o);
    end else begin
      cur[zz2nat[zz]] = data * qm[tbl][zz];
      if (last) begin
        exp_q.push_back(cur);
        cur = '{default: 0};
      end
    end
  endtask

  task automatic dqt(input int tbl, input int zz, input int val);
    dqt_wr_i    = 1'b1;
    dqt_table_i = 2'(tbl);
    dqt_idx_i   = 6'(zz);
    dqt_data_i  = 8'(val);
    @(posedge clk);
    #2;
    dqt_wr_i = 1'b0;
    qm[tbl][zz] = val;
  endtask

  task automatic wait_rx(input int n);
    int g = 0;
    do begin @(posedge clk); g++; end while (rx_blk < n && g < 5000);
    #2;
    if (rx_blk < n) begin
      checks++; errors++;
      $display("FAIL wait_rx: received %0d blocks, required %0d", rx_blk, n);
    end
  endtask

  initial begin
    build_zz();
    cur = '{default: 0};
    rst_i = 1'b1; img_start_i = 1'b0; dqt_wr_i = 1'b0;
    dqt_table_i = '0; dqt_idx_i = '0; dqt_data_i = '0;
    inport_valid_i = 1'b0; inport_data_i = '0; inport_idx_i = '0;
    inport_table_i = '0; inport_last_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_i = 1'b0;
    chk("reset_v_o", {31'd0, v_o}, 32'd0);
    chk("reset_ready_o", {31'd0, ready_o}, 32'd1);
    chk("reset_idx", {26'd0, outport_idx_o}, 32'd0);
    chk("reset_data", outport_data_o, 32'd0);

    for (int z = 0; z < 64; z++) begin
      dqt(0, z, 2);
      dqt(1, z, (z == 0) ? 255 : 1);
      dqt(2, z, z + 1);
      dqt(3, z, (z % 2 == 1) ? 0 : 3);
    end

    // Block 0: full ramp; block 1: most negative coefficient, max q.
    for (int z = 0; z < 64; z++) send(z + 1, z, 0, z == 63);
    send(-32768, 0, 1, 1'b1);
    wait_rx(2);

    // Blocks 2/3 fill both banks with the consumer stalled; block 4 waits.
    ymode = 0;
    for (int z = 0; z < 64; z++) send(z * 37 - 1000, z, 2, z == 63);
    for (int z = 0; z < 64; z++) send(32767 - z * 500, z, 3, z == 63);
    fork
      begin
        send(100, 0, 2, 1'b0);
        send(-7, 1, 2, 1'b0);
        send(50, 3, 2, 1'b0);
        send(-20, 3, 2, 1'b0);
        send(9, 7, 2, 1'b1);
      end
    join_none
    repeat (5) @(posedge clk);
    #2;
    chk("stall_ready_low", {31'd0, ready_o}, 32'd0);
    chk("stall_v_o", {31'd0, v_o}, 32'd1);
    chk("stall_idx_hold", {26'd0, outport_idx_o}, 32'd0);
    ymode = 1;
    repeat (64) @(posedge clk);
    #2;
    chk("ready_before_release", {31'd0, ready_o}, 32'd0);
    @(posedge clk);
    #2;
    chk("ready_after_release", {31'd0, ready_o}, 32'd1);
    wait_rx(5);

    // Block 5: consumer accepts every other cycle.
    ymode = 2;
    for (int z = 0; z < 64; z++) send(z * 100 - 3000, z, 3, z == 63);
    wait_rx(6);
    ymode = 1;

    // Block 6 interrupted by img_start at idx 20 with a write in flight.
    for (int z = 0; z < 64; z++) send(z + 100, z, 2, z == 63);
    for (int i = 0; i < 5; i++) send(11, 10 + i, 2, 1'b0);
    begin
      int g = 0;
      do begin @(negedge clk); g++; end while (!(v_o && outport_idx_o == 6'd19) && g < 2000);
      if (g >= 2000) begin
        checks++; errors++;
        $display("FAIL wait_idx19: idx %0d v_o %0b", outport_idx_o, v_o);
      end
    end
    #1;
    inport_valid_i = 1'b1; inport_data_i = 16'd77; inport_idx_i = 6'd20;
    inport_table_i = 2'd2; inport_last_i = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_flush_idx", {26'd0, outport_idx_o}, 32'd20);
    img_start_i = 1'b1;
    inport_idx_i = 6'd21;
    @(posedge clk);
    #2;
    img_start_i = 1'b0;
    inport_valid_i = 1'b0;
    cur = '{default: 0};
    chk("flush_v_o", {31'd0, v_o}, 32'd0);
    chk("flush_ready_o", {31'd0, ready_o}, 32'd1);
    chk("flush_idx", {26'd0, outport_idx_o}, 32'd0);

    // Block 7: sparse, over the stale bank.
    send(5, 0, 2, 1'b0);
    send(-3, 63, 2, 1'b1);
    wait_rx(8);

    // Blocks 8/9: q rewritten in the same cycle it is read.
    dqt_table_i = 2'd0; dqt_idx_i = 6'd5; dqt_data_i = 8'd7; dqt_wr_i = 1'b1;
    send(3, 5, 0, 1'b1);
    dqt_wr_i = 1'b0;
    qm[0][5] = 7;
    send(3, 5, 0, 1'b1);
    wait_rx(10);

    chk("blk0_idx8", got[0][8], 32'd6);
    chk("blk0_idx2", got[0][2], 32'd12);
    chk("blk0_idx63", got[0][63], 32'd128);
    chk("blk1_idx0", got[1][0], 32'hFF80_8000);
    chk("blk1_idx1", got[1][1], 32'd0);
    chk("blk4_overwrite", got[4][16], 32'hFFFF_FFB0);
    chk("blk4_zero_run", got[4][2], 32'd0);
    chk("blk7_idx0", got[7][0], 32'd5);
    chk("blk7_idx63", got[7][63], 32'hFFFF_FF40);
    chk("blk7_no_stale", got[7][1], 32'd0);
    chk("blk8_old_q", got[8][2], 32'd6);
    chk("blk8_no_stale", got[8][32], 32'd0);
    chk("blk9_new_q", got[9][2], 32'd21);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
